// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the byte-lane RAM port controller: access sizes,
// controller states, requester ids and the registered request payload.
package ram_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10,
        ST_ERR    = 2'b11
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

    // Granted request as held for the response phase
    typedef struct packed {
        gnt_e       gnt;
        logic       we;
        size_e      size;
        logic [1:0] lane;
        logic       uns;
    } req_t;

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane helper: lane select and store replication from size/offset,
// plus alignment and sign/zero extension of a raw RAM word.
module ram_lane_align
    import ram_ctrl_pkg::*;
(
    input  size_e             size,
    input  logic [1:0]        a,
    input  logic              uns,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_raw,
    output logic [LANES-1:0]  bank_sel,
    output logic [DATA_W-1:0] di_repl,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Only the lanes that were enabled carry fresh data
    assign byte_v = rdata_raw[{a, 3'b000} +: 8];
    assign half_v = rdata_raw[{a[1], 4'b0000} +: 16];

    always_comb begin
        bank_sel   = '0;
        di_repl    = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                bank_sel  = LANES'(4'b0001 << a);
                di_repl   = {4{wdata[7:0]}};
                rdata_ext = {{24{~uns & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                misaligned = a[0];
                bank_sel   = a[1] ? 4'b1100 : 4'b0011;
                di_repl    = {2{wdata[15:0]}};
                rdata_ext  = {{16{~uns & half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                misaligned = (a != 2'b00);
                bank_sel   = 4'b1111;
                di_repl    = wdata;
                rdata_ext  = rdata_raw;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter between instruction fetch and data load/store ports
// in front of a 4-bank byte-lane RAM with a 1-cycle registered read.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_enable,
    output logic [LANES-1:0]  ram_bank_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_do
);

    state_e state;
    gnt_e   last_grant;
    req_t   req;

    gnt_e              gnt_c;
    logic              gnt_any_c;
    size_e             sel_size_c;
    logic [1:0]        sel_lane_c;
    logic              sel_uns_c;
    logic              sel_we_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [RAM_AW-1:0] sel_waddr_c;

    logic [LANES-1:0]  sel_bank_c;
    logic [DATA_W-1:0] sel_di_c;
    logic              sel_mis_c;
    logic [DATA_W-1:0] sel_rdata_unused;

    logic [DATA_W-1:0] load_rdata_c;
    logic [LANES-1:0]  load_bank_unused;
    logic [DATA_W-1:0] load_di_unused;
    logic              load_mis_unused;

    // Grant: single requester wins outright, a tie goes to whoever lost last time
    always_comb begin
        gnt_any_c = if_req | d_req;
        gnt_c     = GNT_D;
        if (if_req && d_req) begin
            gnt_c = (last_grant == GNT_D) ? GNT_IF : GNT_D;
        end else if (if_req) begin
            gnt_c = GNT_IF;
        end
    end

    always_comb begin
        sel_size_c  = SZ_WORD;
        sel_lane_c  = if_addr[1:0];
        sel_uns_c   = 1'b1;
        sel_we_c    = 1'b0;
        sel_wdata_c = '0;
        sel_waddr_c = RAM_AW'(if_addr[ADDR_W-1:2]);
        if (gnt_c == GNT_D) begin
            sel_size_c  = size_e'(d_size);
            sel_lane_c  = d_addr[1:0];
            sel_uns_c   = d_unsigned;
            sel_we_c    = d_we;
            sel_wdata_c = d_wdata;
            sel_waddr_c = RAM_AW'(d_addr[ADDR_W-1:2]);
        end
    end

    ram_lane_align u_sel_align (
        .size       (sel_size_c),
        .a          (sel_lane_c),
        .uns        (sel_uns_c),
        .wdata      (sel_wdata_c),
        .rdata_raw  ('0),
        .bank_sel   (sel_bank_c),
        .di_repl    (sel_di_c),
        .rdata_ext  (sel_rdata_unused),
        .misaligned (sel_mis_c)
    );

    ram_lane_align u_load_align (
        .size       (req.size),
        .a          (req.lane),
        .uns        (req.uns),
        .wdata      ('0),
        .rdata_raw  (ram_do),
        .bank_sel   (load_bank_unused),
        .di_repl    (load_di_unused),
        .rdata_ext  (load_rdata_c),
        .misaligned (load_mis_unused)
    );

    // ram_do is only valid in RESP, so read data is steered straight through while ack is up
    assign if_rdata = (if_ack && !if_err) ? load_rdata_c : '0;
    assign d_rdata  = (d_ack && !d_err && !req.we) ? load_rdata_c : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= GNT_D;
            req          <= '0;
            if_ack       <= 1'b0;
            if_err       <= 1'b0;
            d_ack        <= 1'b0;
            d_err        <= 1'b0;
            ram_enable   <= 1'b0;
            ram_we       <= 1'b0;
            ram_bank_sel <= '0;
            ram_addr     <= '0;
            ram_di       <= '0;
        end else begin
            if_ack       <= 1'b0;
            if_err       <= 1'b0;
            d_ack        <= 1'b0;
            d_err        <= 1'b0;
            ram_enable   <= 1'b0;
            ram_we       <= 1'b0;
            ram_bank_sel <= '0;
            ram_addr     <= '0;
            ram_di       <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any_c) begin
                        last_grant <= gnt_c;
                        req        <= '{gnt: gnt_c, we: sel_we_c, size: sel_size_c,
                                        lane: sel_lane_c, uns: sel_uns_c};
                        if (sel_mis_c) begin
                            state <= ST_ERR;
                            if (gnt_c == GNT_IF) begin
                                if_ack <= 1'b1;
                                if_err <= 1'b1;
                            end else begin
                                d_ack <= 1'b1;
                                d_err <= 1'b1;
                            end
                        end else begin
                            state        <= ST_ACCESS;
                            ram_enable   <= 1'b1;
                            ram_we       <= sel_we_c;
                            ram_bank_sel <= sel_bank_c;
                            ram_addr     <= sel_waddr_c;
                            ram_di       <= sel_we_c ? sel_di_c : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                    if (req.gnt == GNT_IF) begin
                        if_ack <= 1'b1;
                    end else begin
                        d_ack <= 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 4-bank byte-lane RAM.
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic        d_unsigned = 1'b0;
    logic [11:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        ram_enable;
    logic [3:0]  ram_bank_sel;
    logic [9:0]  ram_addr;
    logic [31:0] ram_di;
    logic        ram_we;
    logic [31:0] ram_do = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];
    int          en_cnt = 0;
    int          d_ack_cnt = 0;
    logic [3:0]  cap_sel;
    logic [31:0] cap_di;
    logic        cap_we;
    logic [9:0]  cap_addr;

    ram_port_arbiter #(.ADDR_W(12), .RAM_AW(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .if_err       (if_err),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_size       (d_size),
        .d_unsigned   (d_unsigned),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .ram_enable   (ram_enable),
        .ram_bank_sel (ram_bank_sel),
        .ram_addr     (ram_addr),
        .ram_di       (ram_di),
        .ram_we       (ram_we),
        .ram_do       (ram_do)
    );

    always #5 clock = ~clock;

    // RAM model: per-lane write, per-lane registered read, unselected lanes keep stale data
    always @(posedge clock) begin
        if (ram_enable) begin
            for (int n = 0; n < 4; n++) begin
                if (ram_bank_sel[n]) begin
                    if (ram_we) mem[ram_addr][8*n +: 8] <= ram_di[8*n +: 8];
                    else        ram_do[8*n +: 8] <= mem[ram_addr][8*n +: 8];
                end
            end
            en_cnt   = en_cnt + 1;
            cap_sel  = ram_bank_sel;
            cap_di   = ram_di;
            cap_we   = ram_we;
            cap_addr = ram_addr;
        end
        if (d_ack) d_ack_cnt = d_ack_cnt + 1;
    end

    task automatic run_d(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [11:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
        d_we = we; d_size = sz; d_unsigned = uns; d_addr = addr; d_wdata = wd;
        d_req = 1'b1;
        lat = -1; rd = 'x; err = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock); #1;
            if (d_ack) begin
                lat = c; rd = d_rdata; err = d_err;
                break;
            end
        end
        d_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic run_if(input logic [11:0] addr, output logic [31:0] rd,
                          output logic err, output int lat);
        if_addr = addr;
        if_req  = 1'b1;
        lat = -1; rd = 'x; err = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock); #1;
            if (if_ack) begin
                lat = c; rd = if_rdata; err = if_err;
                break;
            end
        end
        if_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        logic [115:0] outs;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        outs = {if_ack, if_err, if_rdata, d_ack, d_err, d_rdata, ram_enable,
                ram_bank_sel, ram_addr, ram_di, ram_we};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (ram_enable !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: en=%b if_ack=%b d_ack=%b expected 0", ram_enable, if_ack, d_ack);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] rd; logic err; int lat;
        run_if(12'h000, rd, err, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL fetch_latency: got %0d expected 2", lat); end
        checks++;
        if (rd !== 32'h8877_66F5) begin errors++; $display("FAIL fetch_rdata: got %h expected 887766f5", rd); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL fetch_err: got %b expected 0", err); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic err; int lat;
        run_d(1'b0, 2'b00, 1'b0, 12'h000, '0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFF_FFF5 || err !== 1'b0 || lat !== 2) begin
            errors++; $display("FAIL lb_signed: got %h err=%b lat=%0d expected fffffff5 0 2", rd, err, lat);
        end
        run_d(1'b0, 2'b00, 1'b1, 12'h000, '0, rd, err, lat);
        checks++;
        if (rd !== 32'h0000_00F5 || err !== 1'b0) begin
            errors++; $display("FAIL lb_unsigned: got %h err=%b expected 000000f5 0", rd, err);
        end
        run_d(1'b0, 2'b01, 1'b0, 12'h002, '0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFF_8877 || err !== 1'b0) begin
            errors++; $display("FAIL lh_signed: got %h err=%b expected ffff8877 0", rd, err);
        end
        run_d(1'b0, 2'b01, 1'b1, 12'h002, '0, rd, err, lat);
        checks++;
        if (rd !== 32'h0000_8877) begin
            errors++; $display("FAIL lh_unsigned: got %h expected 00008877", rd);
        end
        run_d(1'b0, 2'b00, 1'b0, 12'h003, '0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFF_FF88) begin
            errors++; $display("FAIL lb_lane3: got %h expected ffffff88", rd);
        end
    endtask

    task automatic test_store_byte();
        logic [31:0] rd; logic err; int lat; int e0;
        e0 = en_cnt;
        run_d(1'b1, 2'b00, 1'b0, 12'h005, 32'h1234_56AB, rd, err, lat);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sb_ack: lat=%0d err=%b rd=%h expected 2 0 0", lat, err, rd);
        end
        checks++;
        if (en_cnt - e0 !== 1) begin errors++; $display("FAIL sb_enable_cycles: got %0d expected 1", en_cnt - e0); end
        checks++;
        if (cap_sel !== 4'b0010 || cap_di !== 32'hABAB_ABAB || cap_we !== 1'b1 || cap_addr !== 10'd1) begin
            errors++;
            $display("FAIL sb_ram_drive: sel=%b di=%h we=%b addr=%0d expected 0010 abababab 1 1",
                     cap_sel, cap_di, cap_we, cap_addr);
        end
        run_d(1'b0, 2'b10, 1'b0, 12'h004, '0, rd, err, lat);
        checks++;
        if (rd !== 32'h4433_AB11 || err !== 1'b0) begin
            errors++; $display("FAIL sb_readback: got %h err=%b expected 4433ab11 0", rd, err);
        end
        run_d(1'b1, 2'b01, 1'b0, 12'h00A, 32'hFFFF_BEEF, rd, err, lat);
        checks++;
        if (cap_sel !== 4'b1100 || cap_di !== 32'hBEEF_BEEF) begin
            errors++; $display("FAIL sh_ram_drive: sel=%b di=%h expected 1100 beefbeef", cap_sel, cap_di);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat; int e0;
        e0 = en_cnt;
        run_d(1'b0, 2'b10, 1'b0, 12'h006, '0, rd, err, lat);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL lw_misaligned: lat=%0d err=%b rd=%h expected 1 1 0", lat, err, rd);
        end
        run_d(1'b0, 2'b11, 1'b0, 12'h000, '0, rd, err, lat);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL illegal_size: lat=%0d err=%b rd=%h expected 1 1 0", lat, err, rd);
        end
        run_d(1'b1, 2'b01, 1'b0, 12'h001, 32'h1111_2222, rd, err, lat);
        checks++;
        if (lat !== 1 || err !== 1'b1) begin
            errors++; $display("FAIL sh_misaligned: lat=%0d err=%b expected 1 1", lat, err);
        end
        run_if(12'h002, rd, err, lat);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL fetch_misaligned: lat=%0d err=%b rd=%h expected 1 1 0", lat, err, rd);
        end
        checks++;
        if (en_cnt !== e0) begin errors++; $display("FAIL err_no_ram: enables=%0d expected 0", en_cnt - e0); end
    endtask

    task automatic test_round_robin();
        int order [4];
        int n;
        int both;
        logic [31:0] exp_rd [4];
        logic [31:0] got_rd [4];
        exp_rd[0] = 32'h8877_66F5; exp_rd[1] = 32'h4433_AB11;
        exp_rd[2] = 32'h8877_66F5; exp_rd[3] = 32'h4433_AB11;
        n = 0; both = 0;
        reset = 1'b1;
        if_addr = 12'h000; if_req = 1'b1;
        d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 12'h004; d_req = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(posedge clock); #1;
            if (if_ack && d_ack) both++;
            if (if_ack) begin order[n] = 0; got_rd[n] = if_rdata; n++; end
            else if (d_ack) begin order[n] = 1; got_rd[n] = d_rdata; n++; end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clock); #1;
        checks++;
        if (n !== 4 || both !== 0) begin
            errors++; $display("FAIL rr_ack_count: got %0d acks (%0d overlapping) expected 4 (0)", n, both);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] !== (i % 2) || got_rd[i] !== exp_rd[i]) begin
                errors++;
                $display("FAIL rr_grant_%0d: got port=%0d data=%h expected port=%0d data=%h",
                         i, order[i], got_rd[i], i % 2, exp_rd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat; int a0;
        d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b1; d_addr = 12'h000; d_req = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (ram_enable !== 1'b1) begin errors++; $display("FAIL mid_access: ram_enable=%b expected 1", ram_enable); end
        a0 = d_ack_cnt;
        reset = 1'b1;
        #1;
        checks++;
        if ({ram_enable, ram_bank_sel, ram_addr, ram_di, ram_we, d_ack, d_err, d_rdata, if_ack} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: en=%b sel=%b addr=%h di=%h we=%b d_ack=%b expected all 0",
                     ram_enable, ram_bank_sel, ram_addr, ram_di, ram_we, d_ack);
        end
        d_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (d_ack_cnt !== a0) begin errors++; $display("FAIL mid_no_ack: got %0d acks expected 0", d_ack_cnt - a0); end
        run_d(1'b0, 2'b00, 1'b1, 12'h001, '0, rd, err, lat);
        checks++;
        if (rd !== 32'h0000_0066 || err !== 1'b0 || lat !== 2) begin
            errors++; $display("FAIL mid_recover: got %h err=%b lat=%0d expected 00000066 0 2", rd, err, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0] = 32'h8877_66F5;
        mem[1] = 32'h4433_2211;
        test_reset();
        test_fetch();
        test_load_ext();
        test_store_byte();
        test_errors();
        test_round_robin();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
